interrupt_ctrl: RTL
===================

// Module: interrupt_ctrl
// PURPOSE
//   GameBoy interrupt controller. Owns IF (0xFF0F) and IE (0xFFFF).
//   Latches level requests from timer, PPU, serial and joypad into IF.
//   Arbitrates by fixed priority and runs the CPU dispatch handshake (req/vector/ack).
//   Returns a per-source ack so peripherals drop their request.
//   Sits between the peripherals and the CPU core on the 16-bit IO bus.
// PARAMETERS
//   NUM_IRQ   5         number of interrupt sources (bit0 = highest priority)
//   IF_ADDR   16'hFF0F  IF register address
//   IE_ADDR   16'hFFFF  IE register address
//   VEC_BASE  8'h40     vector of source 0; source i -> VEC_BASE + 8*i
// PORTS
//   clk          in   1        system clock (4 MHz domain)
//   rst_n        in   1        asynchronous, active-low reset
//   ct           in   2        machine-cycle phase; dispatch decisions only when ct==2'b00
//   a            in   16       bus address
//   din          in   8        bus write data
//   dout         out  8        bus read data, combinational; 8'hFF when not addressed
//   rd           in   1        bus read strobe
//   wr           in   1        bus write strobe
//   irq_in       in   NUM_IRQ  level requests (bit2 = timer int_tim_req)
//   irq_ack      out  NUM_IRQ  one-cycle ack pulse to the source (bit2 = timer int_tim_ack)
//   ime          in   1        CPU master interrupt enable
//   cpu_int_req  out  1        dispatch request to the CPU
//   cpu_int_vec  out  8        vector address, valid while cpu_int_req=1
//   cpu_int_ack  in   1        CPU accepts the dispatch (single-cycle pulse)
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     IF=0, IE=0, state=IDLE.
//     irq_ack=0, cpu_int_req=0, cpu_int_vec=8'h00, any dispatch in flight is abandoned.
//   IF set and clear:
//     - IF[i] sets on a rising edge of irq_in[i]; the previous value is sampled every clk.
//     - A write to IF_ADDR loads din[4:0]. Read IF = {3'b111, IF}.
//     - Same-cycle rising edge and write-0 on one bit: the set wins.
//     - Any IF[i] 1->0 transition (dispatch or software write) pulses irq_ack[i] for 1 cycle the next clk.
//   IE: full 8-bit read/write at IE_ADDR. Only IE[NUM_IRQ-1:0] gates dispatch.
//   pending = IF & IE[NUM_IRQ-1:0]. Priority: lowest set index wins.
//   FSM:
//     IDLE -> REQ  when ct==2'b00 && ime && |pending; cpu_int_req=1 from the next cycle.
//     REQ:
//       - cpu_int_vec is live: VEC_BASE+8*idx of the current highest pending bit.
//       - If pending goes to 0 during REQ (IE/IF written), vec=8'h00 and req stays high (IE-push cancel quirk).
//     REQ -> ACK  on cpu_int_ack. The index (or 'none') is captured in that cycle.
//     ACK:
//       - cpu_int_req=0.
//       - Clear IF[idx]; irq_ack[idx] pulses the following cycle.
//       - No clear when 'none'.
//       - Next state IDLE.
//     ime dropping while in REQ does not withdraw the request; only the CPU ack or reset ends REQ.
//   Latency:
//     - irq_in edge -> IF set: 1 clk.
//     - IF set -> cpu_int_req: 1 clk after the next ct==0 cycle.
//     - cpu_int_ack -> irq_ack pulse: 2 clk.
//   Bus write vs ACK clear of the same IF bit in the same cycle: the bus write value wins.
//     No ack is emitted unless the bit ends at 0.
// CONFIGURATION
//   INTC_HALT_WAKE_EN defined:
//     - Adds input cpu_halted and output wake.
//     - wake is registered; it asserts 1 clk after |pending while cpu_halted, regardless of ime.
//     - wake clears when pending==0 or cpu_halted==0.
//   INTC_HALT_WAKE_EN undefined: no ports are added and no wake logic is built.
// STRUCTURE
//   Shared package gb_pkg:
//     - IRQ index constants IRQ_VBLANK=0, IRQ_STAT=1, IRQ_TIMER=2, IRQ_SERIAL=3, IRQ_JOYPAD=4.
//     - IO address constants.
//     - FSM state encoding intc_state_t {IDLE, REQ, ACK}.
//   Sub-module intc_prio_enc: NUM_IRQ-bit pending -> {valid, idx}, purely combinational.
//     It is used for both the live vector and the captured index.
// TESTING
//   1. Timer request:
//      - Setup: IE=8'h04, ime=1, then raise irq_in[2].
//      - Expect IF=5'h04, then cpu_int_req=1 with vec=8'h50.
//      - Drive cpu_int_ack: IF=0, irq_ack[2] is a single pulse, req drops.
//   2. Priority:
//      - Setup: IE=8'h1F, irq_in[4] and irq_in[0] raised in the same cycle.
//      - Expect vec=8'h40 first. After the ack, vec=8'h60 and IF=5'h10.
//   3. Cancel:
//      - Setup: request for 8'h50 pending in REQ, then write IE=8'h00.
//      - Expect vec=8'h00. After cpu_int_ack, IF stays 5'h04 and no irq_ack.
//   4. Set/clear race:
//      - Same cycle: write IF=8'h00 and a rising edge on irq_in[1].
//      - Expect IF[1]=1 and no irq_ack[1].
//      - Readback of IF_ADDR = 8'hE2.
//   5. Reset mid-dispatch: drop rst_n while in REQ.
//      - Expect cpu_int_req=0, IF=0 and IE=0 immediately, asynchronously, without waiting for a clk edge.
//   6. Gating:
//      - ime=0 with pending set: expect no cpu_int_req.
//      - With INTC_HALT_WAKE_EN and cpu_halted=1: expect wake=1 after 1 clk.

Source files
------------

// File: rtl/gb_pkg.sv
// Shared GameBoy definitions: IRQ source indices, IO addresses and the
// interrupt-controller dispatch state encoding.
package gb_pkg;

  localparam int unsigned INTC_NUM_IRQ = 5;

  // Interrupt sources, bit 0 is the highest priority
  localparam int unsigned IRQ_VBLANK = 0;
  localparam int unsigned IRQ_STAT   = 1;
  localparam int unsigned IRQ_TIMER  = 2;
  localparam int unsigned IRQ_SERIAL = 3;
  localparam int unsigned IRQ_JOYPAD = 4;

  // IO register addresses
  localparam logic [15:0] GB_IF_ADDR = 16'hFF0F;
  localparam logic [15:0] GB_IE_ADDR = 16'hFFFF;

  // Vector of source 0; source i dispatches to base + 8*i
  localparam logic [7:0] INTC_VEC_BASE = 8'h40;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2
  } intc_state_t;

endpackage

// File: rtl/intc_prio_enc.sv
// Fixed-priority encoder: the lowest set bit of pending wins.
// Ports:
//   pending  in   N     request vector
//   valid    out  1     any bit set (combinational)
//   idx      out  IDXW  index of the lowest set bit, 0 when none (combinational)
module intc_prio_enc
  import gb_pkg::*;
#(
  parameter int unsigned N    = INTC_NUM_IRQ,
  parameter int unsigned IDXW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    pending,
  output logic            valid,
  output logic [IDXW-1:0] idx
);

  // Scan high to low so the lowest set index is written last
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pending[i]) begin
        valid = 1'b1;
        idx   = IDXW'(i);
      end
    end
  end

endmodule

// File: rtl/interrupt_ctrl.sv
// GameBoy interrupt controller: owns IF and IE, latches rising edges of the
// peripheral level requests, and runs the req/vector/ack dispatch to the CPU.
// Optional feature macro: INTC_HALT_WAKE_EN (adds cpu_halted input, wake output).
// Ports:
//   clk, rst_n           clock, async active-low reset
//   ct                   machine-cycle phase; dispatch starts only when ct==0
//   a, din, rd, wr       IO bus; dout is combinational, 8'hFF when not addressed
//   irq_in / irq_ack     level requests in, one-cycle per-source ack out
//   ime                  CPU master interrupt enable
//   cpu_int_req/vec/ack  dispatch handshake with the CPU core
module interrupt_ctrl
  import gb_pkg::*;
#(
  parameter int unsigned NUM_IRQ  = INTC_NUM_IRQ,
  parameter logic [15:0] IF_ADDR  = GB_IF_ADDR,
  parameter logic [15:0] IE_ADDR  = GB_IE_ADDR,
  parameter logic [7:0]  VEC_BASE = INTC_VEC_BASE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         ct,
  input  logic [15:0]        a,
  input  logic [7:0]         din,
  output logic [7:0]         dout,
  input  logic               rd,
  input  logic               wr,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic [NUM_IRQ-1:0] irq_ack,
  input  logic               ime,
`ifdef INTC_HALT_WAKE_EN
  input  logic               cpu_halted,
  output logic               wake,
`endif
  output logic               cpu_int_req,
  output logic [7:0]         cpu_int_vec,
  input  logic               cpu_int_ack
);

  localparam int unsigned IDXW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  intc_state_t        state_q, state_d;
  logic [NUM_IRQ-1:0] if_q, if_d;
  logic [7:0]         ie_q, ie_d;
  logic [NUM_IRQ-1:0] irq_prev_q;
  logic [NUM_IRQ-1:0] rise;
  logic               cap_valid_q;
  logic [IDXW-1:0]    cap_idx_q;
  logic [NUM_IRQ-1:0] clr_mask;

  logic               live_valid, nxt_valid;
  logic [IDXW-1:0]    live_idx, nxt_idx;

  assign rise     = irq_in & ~irq_prev_q;
  assign clr_mask = NUM_IRQ'(1) << cap_idx_q;

  // Current pending drives the dispatch decision and the index capture
  intc_prio_enc #(.N(NUM_IRQ), .IDXW(IDXW)) u_prio_live (
    .pending (if_q & ie_q[NUM_IRQ-1:0]),
    .valid   (live_valid),
    .idx     (live_idx)
  );

  // Next-cycle pending feeds the registered vector so it tracks IF/IE exactly
  intc_prio_enc #(.N(NUM_IRQ), .IDXW(IDXW)) u_prio_nxt (
    .pending (if_d & ie_d[NUM_IRQ-1:0]),
    .valid   (nxt_valid),
    .idx     (nxt_idx)
  );

  // Bus read mux
  always_comb begin
    dout = 8'hFF;
    if (rd && a == IF_ADDR) begin
      dout[NUM_IRQ-1:0] = if_q;
    end else if (rd && a == IE_ADDR) begin
      dout = ie_q;
    end
  end

  // Next state and next IF/IE; priority: ack clear < bus write < rising edge
  always_comb begin
    state_d = state_q;
    if_d    = if_q;
    ie_d    = ie_q;
    unique case (state_q)
      IDLE: if (ct == 2'b00 && ime && live_valid) state_d = REQ;
      REQ:  if (cpu_int_ack) state_d = ACK;
      ACK: begin
        state_d = IDLE;
        if (cap_valid_q) if_d = if_q & ~clr_mask;
      end
      default: state_d = IDLE;
    endcase
    if (wr && a == IF_ADDR) if_d = din[NUM_IRQ-1:0];
    if (wr && a == IE_ADDR) ie_d = din;
    if_d = if_d | rise;
  end

  // State, registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      if_q        <= '0;
      ie_q        <= 8'h00;
      irq_prev_q  <= '0;
      cap_valid_q <= 1'b0;
      cap_idx_q   <= '0;
      irq_ack     <= '0;
      cpu_int_req <= 1'b0;
      cpu_int_vec <= 8'h00;
    end else begin
      state_q     <= state_d;
      if_q        <= if_d;
      ie_q        <= ie_d;
      irq_prev_q  <= irq_in;
      irq_ack     <= if_q & ~if_d;
      cpu_int_req <= (state_d == REQ);
      // Pending vanishing during REQ leaves req high with a null vector
      cpu_int_vec <= (state_d == REQ && nxt_valid)
                     ? 8'(VEC_BASE + (8'(nxt_idx) << 3)) : 8'h00;
      if (state_q == REQ && cpu_int_ack) begin
        cap_valid_q <= live_valid;
        cap_idx_q   <= live_idx;
      end
    end
  end

`ifdef INTC_HALT_WAKE_EN
  // Wake from HALT on any enabled pending request, independent of ime
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wake <= 1'b0;
    else        wake <= cpu_halted && live_valid;
  end
`endif

endmodule
